syn_fifo: RTL and testbench



---
 rtl/syn_fifo_if.sv | 31 +++
 rtl/syn_fifo.sv | 115 +++++++++++
 tb/tb_syn_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/syn_fifo_if.sv
// Handshake/data bundle for syn_fifo: write side, read side, status flags and thresholds.
// slave = the FIFO itself, master = the producer/consumer logic driving it.
interface syn_fifo_if #(
  parameter int unsigned p_nbit_d = 8,
  parameter int unsigned p_nbit_a = 4
);
  logic                wr;
  logic [p_nbit_d-1:0] wdata;
  logic                full;
  logic                afull;
  logic                rd;
  logic [p_nbit_d-1:0] rdata;
  logic                empty;
  logic                aempty;
  logic [p_nbit_a:0]   level;
  logic [p_nbit_a:0]   afull_th;
  logic [p_nbit_a:0]   aempty_th;
  logic                ovf;
  logic                udf;
  logic                err_clr;

  modport slave (
    input  wr, wdata, rd, afull_th, aempty_th, err_clr,
    output full, afull, rdata, empty, aempty, level, ovf, udf
  );

  modport master (
    output wr, wdata, rd, afull_th, aempty_th, err_clr,
    input  full, afull, rdata, empty, aempty, level, ovf, udf
  );
endinterface

// File: rtl/syn_fifo.sv
// Single-clock power-of-two FIFO with occupancy count, programmable almost flags and
// standard/FWFT read. Sticky ovf/udf flags are built only when SYN_FIFO_ERR_FLAGS_EN is defined.
module syn_fifo #(
  parameter int unsigned p_nbit_d = 8,
  parameter int unsigned p_nbit_a = 4,
  parameter int unsigned p_fwft   = 0
) (
  input logic          clk,
  input logic          rst_n,
  syn_fifo_if.slave    bus
);
  localparam int unsigned         DEPTH   = 1 << p_nbit_a;
  localparam logic [p_nbit_a:0]   c_depth = (p_nbit_a + 1)'(DEPTH);
  localparam logic [p_nbit_a:0]   c_lone  = (p_nbit_a + 1)'(1);
  localparam logic [p_nbit_a-1:0] c_aone  = p_nbit_a'(1);

  logic [p_nbit_d-1:0] mem [DEPTH];
  logic [p_nbit_a-1:0] waddr;
  logic [p_nbit_a-1:0] raddr;
  logic [p_nbit_a:0]   level_q;
  logic                full_w;
  logic                empty_w;
  logic                wr_ok;
  logic                rd_ok;

  // Flags come from the registered level only, so wr/rd never reach them combinationally.
  assign full_w  = (level_q == c_depth);
  assign empty_w = (level_q == '0);
  assign wr_ok   = bus.wr & ~full_w;
  assign rd_ok   = bus.rd & ~empty_w;

  assign bus.full   = full_w;
  assign bus.empty  = empty_w;
  assign bus.afull  = (level_q >= bus.afull_th);
  assign bus.aempty = (level_q <= bus.aempty_th);
  assign bus.level  = level_q;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr   <= '0;
      raddr   <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) begin
        waddr <= waddr + c_aone;
      end
      if (rd_ok) begin
        raddr <= raddr + c_aone;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_q <= level_q + c_lone;
        2'b01:   level_q <= level_q - c_lone;
        default: level_q <= level_q;
      endcase
    end
  end

  generate
    if (p_fwft == 0) begin : g_std_rd
      logic [p_nbit_d-1:0] rdata_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (rd_ok) begin
          rdata_q <= mem[raddr];
        end
      end

      assign bus.rdata = rdata_q;
    end else begin : g_fwft_rd
      // Head word is presented directly; rd only advances the read pointer.
      assign bus.rdata = mem[raddr];
    end
  endgenerate

`ifdef SYN_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  // Set has priority over clear so an event coinciding with err_clr is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr && full_w) begin
        ovf_q <= 1'b1;
      end else if (bus.err_clr) begin
        ovf_q <= 1'b0;
      end
      if (bus.rd && empty_w) begin
        udf_q <= 1'b1;
      end else if (bus.err_clr) begin
        udf_q <= 1'b0;
      end
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.ovf        = 1'b0;
  assign bus.udf        = 1'b0;
`endif

endmodule

// File: tb/tb_syn_fifo.sv
// Bench for syn_fifo: one standard-read and one FWFT instance share the same stimulus
// and are compared against a queue-based reference model, plus directed vectors and sequences.
module tb_syn_fifo;
  localparam int unsigned NB_D  = 8;
  localparam int unsigned NB_A  = 4;
  localparam int unsigned DEPTH = 16;
`ifdef SYN_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr = 1'b0, rd = 1'b0, err_clr = 1'b0;
  logic [NB_D-1:0] wdata = '0;
  logic [NB_A:0]   afull_th  = 5'd12;
  logic [NB_A:0]   aempty_th = 5'd3;

  always #5 clk = ~clk;

  syn_fifo_if #(.p_nbit_d(NB_D), .p_nbit_a(NB_A)) bus_s ();
  syn_fifo_if #(.p_nbit_d(NB_D), .p_nbit_a(NB_A)) bus_f ();

  assign bus_s.wr = wr;          assign bus_f.wr = wr;
  assign bus_s.rd = rd;          assign bus_f.rd = rd;
  assign bus_s.wdata = wdata;    assign bus_f.wdata = wdata;
  assign bus_s.err_clr = err_clr; assign bus_f.err_clr = err_clr;
  assign bus_s.afull_th = afull_th;   assign bus_f.afull_th = afull_th;
  assign bus_s.aempty_th = aempty_th; assign bus_f.aempty_th = aempty_th;

  syn_fifo #(.p_nbit_d(NB_D), .p_nbit_a(NB_A), .p_fwft(0)) u_std (
    .clk(clk), .rst_n(rst_n), .bus(bus_s));
  syn_fifo #(.p_nbit_d(NB_D), .p_nbit_a(NB_A), .p_fwft(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bus_f));

  // Reference model: contents as a queue, last word read, sticky error bits.
  logic [NB_D-1:0] q_m[$];
  logic [NB_D-1:0] rd_m = '0;
  bit              ovf_m = 1'b0, udf_m = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    int unsigned n = q_m.size();
    bit wa = wr && (n < DEPTH);
    bit ra = rd && (n > 0);
    if (ERR_EN) begin
      if (wr && n == DEPTH) ovf_m = 1'b1;
      else if (err_clr)     ovf_m = 1'b0;
      if (rd && n == 0)     udf_m = 1'b1;
      else if (err_clr)     udf_m = 1'b0;
    end
    if (ra) rd_m = q_m.pop_front();
    if (wa) q_m.push_back(wdata);
  endtask

  task automatic check_all();
    int unsigned n = q_m.size();
    chk("level_s",  bus_s.level,  n);
    chk("level_f",  bus_f.level,  n);
    chk("empty_s",  bus_s.empty,  32'(n == 0));
    chk("empty_f",  bus_f.empty,  32'(n == 0));
    chk("full_s",   bus_s.full,   32'(n == DEPTH));
    chk("full_f",   bus_f.full,   32'(n == DEPTH));
    chk("afull_s",  bus_s.afull,  32'(n >= afull_th));
    chk("aempty_s", bus_s.aempty, 32'(n <= aempty_th));
    chk("afull_f",  bus_f.afull,  32'(n >= afull_th));
    chk("aempty_f", bus_f.aempty, 32'(n <= aempty_th));
    chk("ovf_s",    bus_s.ovf,    32'(ovf_m));
    chk("udf_s",    bus_s.udf,    32'(udf_m));
    chk("ovf_f",    bus_f.ovf,    32'(ovf_m));
    chk("udf_f",    bus_f.udf,    32'(udf_m));
    chk("rdata_s",  bus_s.rdata,  32'(rd_m));
    if (n > 0) chk("rdata_f", bus_f.rdata, 32'(q_m[0]));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  typedef struct {
    bit              wr;
    bit              rd;
    logic [NB_D-1:0] wdata;
    int unsigned     exp_level;
    logic [NB_D-1:0] exp_rdata;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'h11, 1, 8'h00};
    vt[1] = '{1'b1, 1'b0, 8'h22, 2, 8'h00};
    vt[2] = '{1'b0, 1'b1, 8'h00, 1, 8'h11};
    vt[3] = '{1'b1, 1'b1, 8'h33, 1, 8'h22};
    vt[4] = '{1'b0, 1'b1, 8'h00, 0, 8'h33};
    vt[5] = '{1'b0, 1'b1, 8'h00, 0, 8'h33};  // read while empty: rdata holds
    vt[6] = '{1'b1, 1'b1, 8'h44, 1, 8'h33};  // empty, wr+rd: only the write lands
    vt[7] = '{1'b0, 1'b1, 8'h00, 0, 8'h44};

    // Reset state
    #1;
    chk("rst_level", bus_s.level, 0);
    chk("rst_empty", bus_s.empty, 1);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all();
    chk("rst_rdata", bus_s.rdata, 0);
    chk("rst_aempty", bus_s.aempty, 1);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      wr = vt[i].wr; rd = vt[i].rd; wdata = vt[i].wdata;
      cycle();
      chk("tbl_level", bus_s.level, vt[i].exp_level);
      chk("tbl_rdata", bus_s.rdata, 32'(vt[i].exp_rdata));
    end
    wr = 1'b0; rd = 1'b0; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;

    // Fill 0x01..0x10 with threshold edges
    for (int i = 1; i <= 16; i++) begin
      wr = 1'b1; wdata = 8'(i);
      cycle();
      if (i == 3)  chk("aempty_at3", bus_s.aempty, 1);
      if (i == 4)  chk("aempty_at4", bus_s.aempty, 0);
      if (i == 11) chk("afull_at11", bus_s.afull, 0);
      if (i == 12) chk("afull_at12", bus_s.afull, 1);
    end
    chk("fill_full", bus_s.full, 1);
    chk("fill_level", bus_s.level, 16);
    wr = 1'b0;
    afull_th = 5'd17; aempty_th = 5'd20;
    #1;
    chk("afull_th_above_depth", bus_s.afull, 0);
    chk("aempty_th_above_depth", bus_s.aempty, 1);
    afull_th = 5'd12; aempty_th = 5'd3;

    // Overflow, then set-wins-over-clear, then clear
    wr = 1'b1; wdata = 8'hAA;
    cycle();
    chk("ovf_drop_level", bus_s.level, 16);
    chk("ovf_flag", bus_s.ovf, 32'(ERR_EN));
    err_clr = 1'b1;
    cycle();
    chk("ovf_set_wins", bus_s.ovf, 32'(ERR_EN));
    wr = 1'b0;
    cycle();
    chk("ovf_cleared", bus_s.ovf, 0);
    err_clr = 1'b0;

    // Full with wr+rd: read lands, write dropped
    wr = 1'b1; rd = 1'b1; wdata = 8'hBB;
    cycle();
    chk("fullwr_level", bus_s.level, 15);
    chk("fullwr_rdata", bus_s.rdata, 8'h01);
    wr = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      cycle();
      chk("readback", bus_s.rdata, 32'(i));
    end

    // Empty with wr+rd
    wr = 1'b1; rd = 1'b1; wdata = 8'hCC;
    cycle();
    chk("emptywr_level", bus_s.level, 1);
    chk("emptywr_udf", bus_s.udf, 32'(ERR_EN));
    wr = 1'b0;
    cycle();
    rd = 1'b0; err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;

    // FWFT fall-through of a single word
    wr = 1'b1; wdata = 8'h5C;
    cycle();
    chk("fwft_rdata", bus_f.rdata, 8'h5C);
    chk("fwft_nonempty", bus_f.empty, 0);
    wr = 1'b0;
    cycle();
    chk("fwft_hold", bus_f.rdata, 8'h5C);
    rd = 1'b1;
    cycle();
    chk("fwft_empty", bus_f.empty, 1);
    rd = 1'b0;

    // Pointer wrap at level 5
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; wdata = 8'(8'h60 + i);
      cycle();
    end
    afull_th = 5'd5;
    #1 chk("afull_th_live_on", bus_s.afull, 1);
    afull_th = 5'd6;
    #1 chk("afull_th_live_off", bus_s.afull, 0);
    afull_th = 5'd12;
    rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wdata = 8'(8'h80 + i);
      cycle();
      chk("wrap_level", bus_s.level, 5);
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    rd = 1'b0;

    // Randomised traffic in phases biased toward fill and drain
    for (int ph = 0; ph < 8; ph++) begin
      int unsigned pw = (ph % 2 == 0) ? 75 : 25;
      afull_th  = 5'($urandom_range(0, 20));
      aempty_th = 5'($urandom_range(0, 20));
      for (int i = 0; i < 250; i++) begin
        wr      = ($urandom_range(0, 99) < pw);
        rd      = ($urandom_range(0, 99) < 100 - pw);
        wdata   = 8'($urandom);
        err_clr = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end
    err_clr = 1'b0;

    // Asynchronous reset mid-operation
    rd = 1'b0; wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata = 8'(8'hD0 + i);
      cycle();
    end
    wr = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_level_s", bus_s.level, 0);
    chk("arst_level_f", bus_f.level, 0);
    chk("arst_empty", bus_s.empty, 1);
    chk("arst_rdata", bus_s.rdata, 0);
    q_m.delete();
    rd_m = '0; ovf_m = 1'b0; udf_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
